// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM arbiter: command encoding, widths, FSM states.
// Imported by the arbiter, its round-robin picker and the testbench.
package mem_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT
  } arb_state_t;

  // 2'b11 is not a real command and must never win arbitration
  function automatic logic is_req(
    input logic [1:0] c
  );
    return (c == MREAD) || (c == MWRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and RAM-side bundles of the shared RAM arbiter.
// Requesters use master, the arbiter presents slave.
interface mem_port_if #(
  parameter int AW = mem_pkg::MEM_ADDR_W,
  parameter int DW = mem_pkg::MEM_DATA_W
);
  logic [1:0]    cmd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output cmd, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  cmd, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

interface ram_if #(
  parameter int AW = mem_pkg::MEM_ADDR_W,
  parameter int DW = mem_pkg::MEM_DATA_W
);
  logic [1:0]    cmd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (
    output cmd, addr, wdata,
    input  rdata
  );

  modport slave (
    input  cmd, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick; ptr=0 favours port 0 on a tie.
// The pointer register is owned by the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = ptr ? 2'b10 : 2'b01;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises cpu (port 0) and loader (port 1) onto the single-port RAM.
// Round-robin grant in IDLE, one ACCESS cycle, RDWAIT for RD_LAT cycles.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  mem_port_if.slave  p0,
  mem_port_if.slave  p1,
  ram_if.master      ram,
  output logic       busy
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  arb_state_t        state;
  arb_state_t        state_nx;
  logic              rr_ptr;
  logic              owner;
  logic [1:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              idle;

  assign req  = {is_req(p1.cmd), is_req(p0.cmd)};
  assign idle = (state == IDLE);
  assign busy = !idle;

  rr_arb2 u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign p0.ready  = reset && idle && gnt[0];
  assign p1.ready  = reset && idle && gnt[1];
  assign p0.rvalid = rvalid0_q;
  assign p1.rvalid = rvalid1_q;
  assign p0.rdata  = rdata0_q;
  assign p1.rdata  = rdata1_q;

  assign ram.cmd   = (state == ACCESS) ? cmd_q : MNONE;
  assign ram.addr  = addr_q;
  assign ram.wdata = wdata_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|gnt) state_nx = ACCESS;
      ACCESS:  state_nx = (cmd_q == MREAD) ? RDWAIT : IDLE;
      RDWAIT:  if (cnt == 2'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      cmd_q     <= MNONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state     <= state_nx;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            owner   <= gnt[1];
            cmd_q   <= gnt[1] ? p1.cmd : p0.cmd;
            addr_q  <= gnt[1] ? p1.addr : p0.addr;
            wdata_q <= gnt[1] ? p1.wdata : p0.wdata;
            rr_ptr  <= gnt[0];
          end
        end
        ACCESS: cnt <= LAT;
        RDWAIT: begin
          cnt <= cnt - 2'd1;
          // last latency cycle: RAM data is valid now
          if (cnt == 2'd1) begin
            if (owner) begin
              rdata1_q  <= ram.rdata;
              rvalid1_q <= 1'b1;
            end else begin
              rdata0_q  <= ram.rdata;
              rvalid0_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data/instruction RAM between two requesters: port 0 (the cpu, via its mem_cmd/mem_addr/write_data/read_data interface) and port 1 (the program loader/debug port).
- Serialises accesses, arbitrates round-robin, and returns read data with a valid pulse so each requester can stall until served.
- Sits between the cpu and the RAM at top level.

Parameters:
- ADDR_W, 9, address width (matches cpu mem_addr).
- DATA_W, 16, data width.
- RD_LAT, 1, RAM read latency in cycles after the command cycle. Legal values 1..3.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- p0_cmd  in  2  port 0 command: 00 NONE, 01 READ, 10 WRITE. 11 is treated as NONE.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ready  out  1  one-cycle pulse: port 0 request accepted this cycle.
- p0_rvalid  out  1  one-cycle pulse: p0_rdata valid.
- p0_rdata  out  DATA_W  port 0 read data, registered.
- p1_cmd, p1_addr, p1_wdata, p1_ready, p1_rvalid, p1_rdata: identical to port 0, for port 1.
- ram_cmd  out  2  command to RAM, same encoding.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after the READ command cycle.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state IDLE; all ready/rvalid 0; rdata 0; ram_cmd NONE; ram_addr 0; ram_wdata 0; rr_ptr 0 (port 0 favoured).
- States: IDLE, ACCESS, RDWAIT.
- IDLE:
  - A port is requesting when its cmd is READ or WRITE.
  - If both ports request, the port selected by rr_ptr wins. If only one requests, it wins.
  - The winner's pX_ready is asserted combinationally in this cycle.
  - On the clock edge, the winner's cmd/addr/wdata and the owner id are captured, rr_ptr is set to the other port, and the state goes to ACCESS.
  - The requester may change its inputs in the cycle after ready. A loser holds its request; it is not dropped.
- ACCESS (exactly 1 cycle):
  - ram_cmd/ram_addr/ram_wdata are driven from the captured registers. In every other state ram_cmd is NONE.
  - WRITE goes to IDLE. READ loads the latency counter with RD_LAT and goes to RDWAIT.
- RDWAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches its last count, sample ram_rdata into the owner's pX_rdata and pulse that port's pX_rvalid on the following cycle, then go to IDLE.
  - The non-owner's rdata is unchanged.
- Latency: a write occupies 2 cycles (IDLE accept + ACCESS). With RD_LAT=1, a read's rvalid is asserted 3 cycles after its ready pulse. Back-to-back grants are therefore at most one every 2 (write) or 2+RD_LAT (read) cycles.
- A new request is never accepted outside IDLE. The rvalid cycle coincides with IDLE, so the next accept may occur in the same cycle as rvalid.
- Ordering: accesses are fully serialised. A read after a write to the same address returns the new data.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1. Neither port waits more than one foreign transaction.
- cmd 11 is never granted and never produces a RAM access.
- Reset mid-operation: everything returns asynchronously to reset values. An in-flight read is discarded (no rvalid). ram_cmd goes to NONE immediately.
- rdata holds its last value until the next read completion for that port.

Decomposition:
- Shared package mem_pkg holds:
  - mem_cmd_t enum: MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10.
  - ADDR_W and DATA_W defaults.
  - arbiter state enum: IDLE, ACCESS, RDWAIT.
- One natural sub-module, rr_arb2: a 2-way round-robin pick.
  - Inputs: two request bits and the pointer.
  - Outputs: one-hot grant.
  - Pointer register lives in the parent.

Test Plan:
- Reset with reset=0, both cmds NONE -> all outputs 0, ram_cmd=00, busy=0. Release reset, idle 5 cycles -> no ready, no RAM access.
- p0 WRITE addr 0x005 data 0x1234 -> p0_ready pulses in the same cycle; next cycle ram_cmd=10, ram_addr=0x005, ram_wdata=0x1234; busy falls the cycle after.
- p1 READ 0x005 after that write, RAM model RD_LAT=1 -> p1_rvalid pulses once, p1_rdata=0x1234; p0_rdata unchanged at 0.
- Both ports continuously READ (p0 0x001, p1 0x002, contents 0x00AA/0x00BB) for 4 grants -> grant order 0,1,0,1; p0 receives 0x00AA, p1 receives 0x00BB.
- p0 READ, reset pulled low during RDWAIT -> no p0_rvalid ever asserted; after release, the next p0 READ completes normally with correct data.
- p0_cmd=11 held 10 cycles -> no ready, ram_cmd stays 00. Repeat at RD_LAT=3 -> rvalid 5 cycles after ready.
